msg_sched: RTL and testbench

MSG_SCHED -- requirements
Module: msg_sched

---
 rtl/msg_sched.sv | 99 +++++++++
 tb/tb_msg_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_sched.sv
// Message schedule generator: loads a 16-word block, then streams ROUNDS schedule words W[t].
// Optional `MSG_SCHED_IDX_EN adds an out_idx port carrying the current round index t.
module msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
  output logic        busy,
`ifdef MSG_SCHED_IDX_EN
  output logic [5:0]  out_idx,
`endif
  output logic        state_dbg
);

  // Handshake: a word moves on any rising edge where valid && ready; valid never waits on ready.
  typedef enum logic {S_LOAD = 1'b0, S_EMIT = 1'b1} state_e;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic [5:0]  t_q, t_d;
  logic        in_fire, out_fire;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      load_cnt_q <= 4'd0;
      t_q        <= 6'd0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      t_q        <= t_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: if (in_fire && load_cnt_q == 4'd15) state_d = S_EMIT;
      S_EMIT: if (out_fire && out_last) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_EMIT);
    out_word  = (state_q == S_EMIT) ? win_q[0] : 32'd0;
    out_last  = (state_q == S_EMIT) && (t_q == LAST_T);
    busy      = (state_q == S_EMIT) || (load_cnt_q != 4'd0);
    state_dbg = state_q;
  end

  // Datapath: load writes win[load_cnt]; emission slides the window and appends W[t+16].
  always_comb begin
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    load_cnt_d = load_cnt_q;
    t_d        = t_q;
    if (state_q == S_LOAD) begin
      t_d = 6'd0;
      if (in_fire) begin
        win_d[load_cnt_q] = in_word;
        load_cnt_d        = load_cnt_q + 4'd1;
      end
    end else if (out_fire) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
      t_d       = out_last ? 6'd0 : t_q + 6'd1;
    end
  end

`ifdef MSG_SCHED_IDX_EN
  assign out_idx = t_q;
`endif

endmodule

// File: tb/tb_msg_sched.sv
// Bench for msg_sched: directed and random blocks checked against a SHA-256 style schedule model.
// A 64-round instance and a 16-round instance share the stimulus, selected by sel.
module tb_msg_sched;

  logic        clk, rst_n, sel;
  logic        in_valid, out_ready;
  logic [31:0] in_word;

  logic        a_in_ready, a_out_valid, a_out_last, a_busy, a_state;
  logic [31:0] a_out_word;
  logic        b_in_ready, b_out_valid, b_out_last, b_busy, b_state;
  logic [31:0] b_out_word;
  logic        c_in_ready, c_out_valid, c_out_last, c_busy, c_state;
  logic [31:0] c_out_word;
`ifdef MSG_SCHED_IDX_EN
  logic [5:0]  a_out_idx, b_out_idx, c_out_idx;
`endif

  logic [31:0] m_arr [16];
  logic [31:0] got [64];
  logic [31:0] exp_q [$];
  int          n_assert = 0;
  int          n_fail   = 0;

  // ---------------- clock / reset / DUTs ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  msg_sched #(.ROUNDS(64)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
    .in_word(in_word), .out_valid(a_out_valid), .out_ready(out_ready && !sel),
    .out_word(a_out_word), .out_last(a_out_last), .busy(a_busy),
`ifdef MSG_SCHED_IDX_EN
    .out_idx(a_out_idx),
`endif
    .state_dbg(a_state)
  );

  msg_sched #(.ROUNDS(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .in_word(in_word), .out_valid(b_out_valid), .out_ready(out_ready && sel),
    .out_word(b_out_word), .out_last(b_out_last), .busy(b_busy),
`ifdef MSG_SCHED_IDX_EN
    .out_idx(b_out_idx),
`endif
    .state_dbg(b_state)
  );

  always_comb begin
    c_in_ready  = sel ? b_in_ready  : a_in_ready;
    c_out_valid = sel ? b_out_valid : a_out_valid;
    c_out_word  = sel ? b_out_word  : a_out_word;
    c_out_last  = sel ? b_out_last  : a_out_last;
    c_busy      = sel ? b_busy      : a_busy;
    c_state     = sel ? b_state     : a_state;
`ifdef MSG_SCHED_IDX_EN
    c_out_idx   = sel ? b_out_idx   : a_out_idx;
`endif
  end

  // ---------------- scoreboard / model ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // W[t] = M[t] for t<16, else s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  task automatic build_exp(input int r);
    logic [31:0] w [64];
    exp_q.delete();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m_arr[t];
      else w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    end
    for (int t = 0; t < r; t++) exp_q.push_back(w[t]);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) m_arr[i] = 32'd0;
    m_arr[0]  = 32'h61626380;
    m_arr[15] = 32'h00000018;
  endtask

  // ---------------- driver tasks ----------------
  // Ends on the falling edge after the n-th word was taken.
  task automatic load_block(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int idle = $urandom_range(0, 2);
        for (int k = 0; k < idle; k++) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      chk("in_ready_load", c_in_ready, 1);
      chk("out_valid_load", c_out_valid, 0);
      chk("busy_load", c_busy, (i == 0) ? 0 : 1);
      in_valid = 1'b1;
      in_word  = m_arr[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mode 0: ready always, 1: pattern 1,0,0, 2: random. Starts checking at the current falling edge.
  task automatic drain(input int r, input int mode, input int stop_after);
    int  acc = 0;
    int  cyc = 0;
    bit  rdy;
    while (acc < stop_after && cyc < r * 4 + 20) begin
      chk("out_valid", c_out_valid, 1);
      chk("in_ready_emit", c_in_ready, 0);
      chk("busy_emit", c_busy, 1);
      chk("out_word", c_out_word, exp_q.size() > 0 ? exp_q[0] : 32'hDEADBEEF);
      chk("out_last", c_out_last, (acc == r - 1) ? 1 : 0);
`ifdef MSG_SCHED_IDX_EN
      chk("out_idx", c_out_idx, acc);
`endif
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      in_valid  = 1'($urandom_range(0, 1));
      in_word   = $urandom;
      if (rdy) begin
        got[acc] = c_out_word;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_accepted", acc, stop_after);
    if (mode == 0) chk("drain_cycles", cyc, stop_after);
    if (stop_after == r) begin
      chk("in_ready_after", c_in_ready, 1);
      chk("out_valid_after", c_out_valid, 0);
      chk("busy_after", c_busy, 0);
      chk("out_word_after", c_out_word, 0);
      chk("state_after", c_state, 0);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_in_ready"}, c_in_ready, 1);
    chk({tag, "_out_valid"}, c_out_valid, 0);
    chk({tag, "_out_word"}, c_out_word, 0);
    chk({tag, "_out_last"}, c_out_last, 0);
    chk({tag, "_busy"}, c_busy, 0);
`ifdef MSG_SCHED_IDX_EN
    chk({tag, "_out_idx"}, c_out_idx, 0);
`endif
  endtask

  task automatic check_abc_words();
    chk("abc_w0", got[0], 32'h61626380);
    chk("abc_w15", got[15], 32'h00000018);
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = 32'd0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // padded "abc" block, ready always high
    set_abc(); build_exp(64);
    load_block(16, 1'b0);
    drain(64, 0, 64);
    check_abc_words();

    // all-zero block: 64 contiguous zero words
    for (int i = 0; i < 16; i++) m_arr[i] = 32'd0;
    build_exp(64);
    load_block(16, 1'b0);
    drain(64, 0, 64);

    // "abc" with ready pattern 1,0,0
    set_abc(); build_exp(64);
    load_block(16, 1'b0);
    drain(64, 1, 64);
    check_abc_words();

    // reset mid-load, asynchronously between clock edges
    for (int i = 0; i < 16; i++) m_arr[i] = $urandom;
    load_block(8, 1'b0);
    chk("busy_partial", c_busy, 1);
    #2 rst_n = 1'b0;
    #1 check_cleared("rst_load");
    @(negedge clk); rst_n = 1'b1;
    set_abc(); build_exp(64);
    load_block(16, 1'b0);
    drain(64, 0, 64);
    check_abc_words();

    // reset after W20 emitted
    build_exp(64);
    load_block(16, 1'b0);
    drain(64, 0, 21);
    chk("out_valid_pre_rst", c_out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_cleared("rst_emit");
    @(negedge clk); rst_n = 1'b1;
    build_exp(64);
    load_block(16, 1'b1);
    drain(64, 0, 64);
    check_abc_words();

    // random blocks, random load gaps and random back-pressure
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) m_arr[i] = $urandom;
      build_exp(64);
      load_block(16, 1'b1);
      drain(64, 2, 64);
    end

    // 16-round instance, M[i] = i
    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) m_arr[i] = i;
    build_exp(16);
    load_block(16, 1'b0);
    drain(16, 0, 16);
    for (int i = 0; i < 16; i++) chk("r16_word", got[i], i);

    // 16-round instance, random block with back-pressure
    for (int i = 0; i < 16; i++) m_arr[i] = $urandom;
    build_exp(16);
    load_block(16, 1'b1);
    drain(16, 2, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
